// File: rtl/jtgng_romarb_pkg.sv
// rtl/jtgng_romarb_pkg.sv - shared types and constants for the video ROM-port arbiter
package jtgng_romarb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    localparam logic [1:0] CHAR = 2'd0;
    localparam logic [1:0] SCR  = 2'd1;
    localparam logic [1:0] OBJ  = 2'd2;

    localparam logic [7:0] TOUT_DEFAULT = 8'd63;

endpackage

// File: rtl/jtgng_rr_pick.sv
// rtl/jtgng_rr_pick.sv - combinational winner selection for the ROM-port arbiter
module jtgng_rr_pick
    import jtgng_romarb_pkg::*;
(
    input  logic [2:0] req,
    input  logic [1:0] last,
    input  logic       blank,
    output logic [1:0] winner,
    output logic       valid
);

    always_comb begin
        winner = CHAR;
        valid  = |req;
        if (blank) begin
            // Objects own the port during blanking; char/scr alternate otherwise.
            if (req[OBJ])
                winner = OBJ;
            else if (req[CHAR] && req[SCR])
                winner = (last == CHAR) ? SCR : CHAR;
            else if (req[SCR])
                winner = SCR;
            else
                winner = CHAR;
        end else begin
            case (last)
                CHAR:    winner = req[SCR]  ? SCR  : (req[OBJ]  ? OBJ  : CHAR);
                SCR:     winner = req[OBJ]  ? OBJ  : (req[CHAR] ? CHAR : SCR);
                default: winner = req[CHAR] ? CHAR : (req[SCR]  ? SCR  : OBJ);
            endcase
        end
    end

endmodule

// File: rtl/jtgng_romarb.sv
// rtl/jtgng_romarb.sv - char/scroll/object arbiter sharing one ROM read port
module jtgng_romarb
    import jtgng_romarb_pkg::*;
#(
    parameter int         AW   = 22,
    parameter int         DW   = 16,
    parameter logic [7:0] TOUT = TOUT_DEFAULT
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          LHBL,
    input  logic          LVBL,
    input  logic          char_req,
    input  logic          scr_req,
    input  logic          obj_req,
    input  logic [AW-1:0] char_addr,
    input  logic [AW-1:0] scr_addr,
    input  logic [AW-1:0] obj_addr,
    output logic          char_ok,
    output logic          scr_ok,
    output logic          obj_ok,
    output logic [DW-1:0] dout,
    output logic          mem_req,
    output logic [AW-1:0] mem_addr,
    input  logic          mem_ack,
    input  logic          mem_rdy,
    input  logic [DW-1:0] mem_din,
    output logic          busy,
    output logic          err
);

    state_t        state, state_nx;
    logic [1:0]    winner, last;
    logic [1:0]    pick;
    logic          pick_valid;
    logic [2:0]    ok;
    logic [7:0]    cnt;
    logic          grant, done, abort, tout_hit;
    logic [AW-1:0] pick_addr;

    jtgng_rr_pick u_pick (
        .req    ({obj_req, scr_req, char_req}),
        .last   (last),
        .blank  (~LHBL | ~LVBL),
        .winner (pick),
        .valid  (pick_valid)
    );

    always_comb begin
        case (pick)
            SCR:     pick_addr = scr_addr;
            OBJ:     pick_addr = obj_addr;
            default: pick_addr = char_addr;
        endcase
    end

    assign tout_hit = (cnt == TOUT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nx;
    end

    // Timeout beats a late ack in ISSUE; a returning read beats the timeout in WAIT.
    always_comb begin
        state_nx = state;
        grant    = 1'b0;
        done     = 1'b0;
        abort    = 1'b0;
        case (state)
            IDLE: begin
                if (pick_valid) begin
                    grant    = 1'b1;
                    state_nx = ISSUE;
                end
            end
            ISSUE: begin
                if (tout_hit) begin
                    abort    = 1'b1;
                    state_nx = IDLE;
                end else if (mem_ack) begin
                    state_nx = WAIT;
                end
            end
            WAIT: begin
                if (mem_rdy) begin
                    done     = 1'b1;
                    state_nx = IDLE;
                end else if (tout_hit) begin
                    abort    = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_req  <= 1'b0;
            mem_addr <= '0;
            dout     <= '0;
            ok       <= 3'b000;
            err      <= 1'b0;
            last     <= OBJ;
            winner   <= CHAR;
            cnt      <= 8'd0;
        end else begin
            ok <= 3'b000;
            if (grant) begin
                winner   <= pick;
                mem_addr <= pick_addr;
                mem_req  <= 1'b1;
                cnt      <= 8'd0;
            end else if (state != IDLE) begin
                cnt <= cnt + 8'd1;
            end
            if (state == ISSUE && state_nx != ISSUE)
                mem_req <= 1'b0;
            if (abort)
                err <= 1'b1;
            if (done) begin
                dout <= mem_din;
                ok   <= 3'b001 << winner;
                last <= winner;
            end
        end
    end

    assign char_ok = ok[CHAR];
    assign scr_ok  = ok[SCR];
    assign obj_ok  = ok[OBJ];
    assign busy    = (state == ISSUE) || (state == WAIT);

endmodule

// File: doc/jtgng_romarb.md
# jtgng_romarb

Shared ROM-port arbiter for the video fetch path. Three video requesters (char, scroll, object) share one ROM/SDRAM read port. The block picks a winner and runs one read at a time through the port. It returns the data with a one-cycle ok strobe to the winner. Priority follows the blanking signals from the video timer: objects win during blanking, and active video uses round-robin.

## Interface
Parameters:
- AW, 22, address width of requesters and memory port
- DW, 16, data width
- TOUT, 8'd63, cycles allowed in ISSUE+WAIT before abort

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- LHBL  in  1  horizontal blanking, low = blank, from video timer
- LVBL  in  1  vertical blanking, low = blank, from video timer
- char_req / scr_req / obj_req  in  1 each  request level
- char_addr / scr_addr / obj_addr  in  AW each  request address; stable while req high
- char_ok / scr_ok / obj_ok  out  1 each  one-cycle pulse when data is valid
- dout  out  DW  data, broadcast to all requesters, valid on the ok cycle
- mem_req  out  1  memory request
- mem_addr  out  AW  memory address
- mem_ack  in  1  memory accepted request
- mem_rdy  in  1  memory data valid
- mem_din  in  DW  memory data
- busy  out  1  high in ISSUE or WAIT
- err  out  1  sticky; set on timeout

## Operation
- FSM states: IDLE, ISSUE, WAIT.
- IDLE:
  - If any req is high: register the winner id, set mem_addr to the winner's addr, set mem_req=1, go to ISSUE.
  - Otherwise stay in IDLE.
- ISSUE:
  - Hold mem_req and mem_addr.
  - On mem_ack: mem_req<=0, go to WAIT.
- WAIT:
  - On mem_rdy: dout<=mem_din, pulse <winner>_ok, last<=winner, go to IDLE.
  - mem_rdy is ignored outside WAIT.
- Blanking rule: blank = ~LHBL | ~LVBL, sampled in IDLE only.
- Blank: obj_req wins if high. Otherwise round-robin between char and scr.
- Active video: round-robin order char→scr→obj, starting at the requester after `last`.
- Timeout:
  - An 8-bit counter clears on entry to ISSUE and increments each cycle in ISSUE or WAIT.
  - When it equals TOUT: mem_req<=0, err<=1, go to IDLE, no ok pulse.
  - The requester's req is still high, so it is re-arbitrated.
- Requester protocol:
  - A requester holds req until its ok pulse.
  - If req is still high in the cycle after ok, that is a new request.
  - If a requester drops req while granted, the transaction still completes and the ok pulse is still issued.

## Timing
- Reset values (async, rst_n low):
  - state=IDLE, mem_req=0, mem_addr=0, dout=0.
  - All ok=0, busy=0, err=0.
  - last=obj, so char wins first in round-robin.
  - Timeout counter=0.
- Latency:
  - req seen in IDLE at cycle 0 → mem_req=1 at cycle 1.
  - mem_ack at cycle a → mem_req=0 at a+1.
  - mem_rdy at cycle n → ok and dout at n+1, state IDLE at n+1.
  - Next mem_req earliest at n+2.
- Memory may assert mem_ack in the first cycle mem_req is high. Memory must not assert mem_rdy before the cycle after mem_ack.
- Exactly one outstanding transaction. ok pulses never overlap.
- Simultaneous events:
  - mem_ack and counter==TOUT in the same cycle: the timeout wins.
  - mem_rdy and timeout in the same cycle: mem_rdy wins, the read completes with ok and err is not set.
- Reset mid-transaction: all state clears immediately and no ok is generated. Memory must tolerate a dropped mem_req.
- err clears only by reset.

## Structure
- Package jtgng_romarb_pkg:
  - state enum {IDLE, ISSUE, WAIT}.
  - Requester id constants CHAR=2'd0, SCR=2'd1, OBJ=2'd2.
  - Default TOUT.
- Sub-module jtgng_rr_pick: purely combinational.
  - Inputs: 3-bit req vector, last id, blank.
  - Outputs: winner id and valid.
  - Instantiated once in this block.

## Test plan
- Single request, active video:
  - Stimulus: char_req=1, char_addr=22'h1234; memory acks at cycle 1 and sets mem_rdy=1, mem_din=16'hBEEF at cycle 4.
  - Response: mem_addr=22'h1234 at cycle 1; char_ok=1 and dout=16'hBEEF at cycle 5 only; scr_ok=obj_ok=0.
- Round-robin, active video: all three reqs held high with LHBL=LVBL=1 → grant order char, scr, obj, char over four transactions.
- Blank priority:
  - Stimulus: LHBL=0, all reqs high.
  - Response: obj granted for consecutive transactions while blank.
  - Then raise LHBL: next grant follows round-robin from last=obj, so char wins.
- Timeout:
  - Stimulus: TOUT=8'd63, memory never sets mem_rdy.
  - Response: mem_req drops and err=1 at the cycle the counter reaches 63; no ok pulse; the same requester is re-issued.
- Async reset in WAIT: drop rst_n with no clock edge → mem_req, busy, ok and err all 0 immediately; after release, char wins first.
- Simultaneous mem_rdy and timeout in the same cycle → ok is pulsed, err stays 0.
